// File: rtl/smpl_pkg.sv
// smpl_pkg: shared types for the SMPL multi-cycle accumulator core.
//   opcode_e - 4-bit instruction opcodes
//   state_e  - core FSM states
//   flags_t  - Z/C/N condition flags
package smpl_pkg;

  localparam int unsigned OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpAnd = 4'd2,
    OpNot = 4'd3,
    OpLda = 4'd4,
    OpSta = 4'd5,
    OpJmp = 4'd6,
    OpJz  = 4'd7,
    OpOr  = 4'd8,
    OpXor = 4'd9,
    OpJc  = 4'd10,
    OpJn  = 4'd11,
    OpShl = 4'd12,
    OpShr = 4'd13,
    OpNop = 4'd14,
    OpHlt = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StExec  = 2'd1,
    StMem   = 2'd2,
    StHalt  = 2'd3
  } state_e;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
  } flags_t;

  // Opcodes that need a data-port transfer after EXEC.
  function automatic logic is_mem_op(opcode_e op);
    return op inside {OpAdd, OpSub, OpAnd, OpNot, OpLda, OpSta, OpOr, OpXor};
  endfunction

endpackage

// File: rtl/smpl_core_p_if.sv
// smpl_core_p_if: instruction-fetch and data-bus handshake signals of the SMPL core.
//   master modport - core side (drives requests, addresses, write data)
//   slave modport  - memory side (drives acks and read data)
interface smpl_core_p_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12
) ();

  localparam int unsigned INSTR_W = smpl_pkg::OPC_W + ADDR_W;

  logic [ADDR_W-1:0]  iaddr;
  logic               ireq;
  logic               iack;
  logic [INSTR_W-1:0] idata;

  logic [ADDR_W-1:0]  daddr;
  logic [DATA_W-1:0]  datao;
  logic [DATA_W-1:0]  datai;
  logic               dreq;
  logic               dwe;
  logic               dack;

  modport master (
    output iaddr, ireq, daddr, datao, dreq, dwe,
    input  iack, idata, datai, dack
  );

  modport slave (
    input  iaddr, ireq, daddr, datao, dreq, dwe,
    output iack, idata, datai, dack
  );

endinterface

// File: rtl/smpl_alu.sv
// smpl_alu: combinational accumulator ALU.
//   opcode_i  - current instruction opcode
//   acc_i     - accumulator value
//   operand_i - memory operand (ignored by shifts)
//   result_o  - new accumulator value
//   flags_o   - Z/C/N derived from result_o and the carry/borrow/shift-out bit
module smpl_alu
  import smpl_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  opcode_e           opcode_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] operand_i,
  output logic [DATA_W-1:0] result_o,
  output flags_t            flags_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic            carry;

  always_comb begin
    sum      = {1'b0, acc_i} + {1'b0, operand_i};
    // Top bit of the widened difference is the borrow (operand > acc, unsigned).
    diff     = {1'b0, acc_i} - {1'b0, operand_i};
    result_o = acc_i;
    carry    = 1'b0;
    case (opcode_i)
      OpAdd: begin
        result_o = sum[DATA_W-1:0];
        carry    = sum[DATA_W];
      end
      OpSub: begin
        result_o = diff[DATA_W-1:0];
        carry    = diff[DATA_W];
      end
      OpAnd: result_o = acc_i & operand_i;
      OpOr:  result_o = acc_i | operand_i;
      OpXor: result_o = acc_i ^ operand_i;
      OpNot: result_o = ~operand_i;
      OpLda: result_o = operand_i;
      OpShl: begin
        result_o = {acc_i[DATA_W-2:0], 1'b0};
        carry    = acc_i[DATA_W-1];
      end
      OpShr: begin
        result_o = {1'b0, acc_i[DATA_W-1:1]};
        carry    = acc_i[0];
      end
      default: begin
        result_o = acc_i;
        carry    = 1'b0;
      end
    endcase
    flags_o.z = (result_o == '0);
    flags_o.c = carry;
    flags_o.n = result_o[DATA_W-1];
  end

endmodule

// File: rtl/smpl_core_p.sv
// smpl_core_p: multi-cycle SMPL accumulator CPU with req/ack instruction and data ports.
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - instruction fetch and data handshake ports (master side)
//   halted  - core stopped by HLT (sticky until reset)
//   acc_o   - accumulator, for debug
module smpl_core_p
  import smpl_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  smpl_core_p_if.master     bus,
  output logic              halted,
  output logic [DATA_W-1:0] acc_o
);

  localparam int unsigned INSTR_W = OPC_W + ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  flags_t              flags_q, flags_d;

  opcode_e             op;
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   alu_result;
  flags_t              alu_flags;

  assign op      = opcode_e'(ir_q[INSTR_W-1 -: OPC_W]);
  assign op_addr = ir_q[ADDR_W-1:0];

  smpl_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .opcode_i  (op),
    .acc_i     (acc_q),
    .operand_i (bus.datai),
    .result_o  (alu_result),
    .flags_o   (alu_flags)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: if (bus.iack) state_d = StExec;
      StExec: begin
        if (op == OpHlt) begin
          state_d = StHalt;
        end else if (is_mem_op(op)) begin
          state_d = StMem;
        end else begin
          state_d = StFetch;
        end
      end
      StMem:   if (bus.dack) state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Datapath next-state: PC, IR, accumulator and flags.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    unique case (state_q)
      StFetch: begin
        if (bus.iack) begin
          ir_d = bus.idata;
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      StExec: begin
        case (op)
          OpJmp: pc_d = op_addr;
          OpJz:  if (flags_q.z) pc_d = op_addr;
          OpJc:  if (flags_q.c) pc_d = op_addr;
          OpJn:  if (flags_q.n) pc_d = op_addr;
          OpShl, OpShr: begin
            acc_d   = alu_result;
            flags_d = alu_flags;
          end
          default: ;
        endcase
      end
      StMem: begin
        if (bus.dack && (op != OpSta)) begin
          acc_d   = alu_result;
          flags_d = alu_flags;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      flags_q <= '{z: 1'b1, c: 1'b0, n: 1'b0};
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

  // Port outputs.
  always_comb begin
    bus.iaddr = pc_q;
    bus.ireq  = 1'b0;
    bus.daddr = '0;
    bus.datao = '0;
    bus.dreq  = 1'b0;
    bus.dwe   = 1'b0;
    halted    = 1'b0;
    acc_o     = acc_q;
    unique case (state_q)
      // The state register already sits in FETCH during reset; keep the request low until release.
      StFetch: bus.ireq = reset_n;
      StExec:  ;
      StMem: begin
        bus.dreq  = 1'b1;
        bus.daddr = op_addr;
        bus.dwe   = (op == OpSta);
        bus.datao = (op == OpSta) ? acc_q : '0;
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_smpl_core_p.sv
module tb_smpl_core_p;

  typedef enum int {PhFetch, PhGap, PhData, PhHalt} ph_e;

  logic        clock;
  logic        reset_n;
  logic        halted;
  logic [15:0] acc_o;

  smpl_core_p_if #(.DATA_W(16), .ADDR_W(12)) bus ();

  smpl_core_p #(
    .DATA_W (16),
    .ADDR_W (12)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .halted  (halted),
    .acc_o   (acc_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] imem [4096];
  logic [15:0] dmem [4096];

  // Memory behaviour knobs.
  int iwait, dwait;
  bit noise;     // pulse ack whenever the matching req is low
  bit active;

  // ISA-level reference model.
  ph_e m_phase;
  int  m_pc, m_ir, m_acc;
  bit  m_z, m_c, m_n;
  int  cyc, halt_cyc, wcount, wcyc;
  bit  logged;
  int  fa[$], fc[$], facc[$];

  // Responder bookkeeping.
  int          ihold, dhold;
  bit          i_fire, d_fire, d_we_s;
  int          d_addr_s;
  logic [15:0] d_data_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_zn();
    m_z = (m_acc == 0);
    m_n = (m_acc >= 32768);
  endtask

  task automatic model_init();
    m_phase = PhFetch;
    m_pc = 0; m_ir = 0; m_acc = 0;
    m_z = 1'b1; m_c = 1'b0; m_n = 1'b0;
    cyc = -1; halt_cyc = -1; wcount = 0; wcyc = 0; logged = 1'b0;
    fa.delete(); fc.delete(); facc.delete();
    ihold = 0; dhold = 0; i_fire = 1'b0; d_fire = 1'b0; d_we_s = 1'b0;
  endtask

  task automatic model_fetch();
    m_ir    = int'(imem[m_pc]);
    m_pc    = (m_pc + 1) % 4096;
    m_phase = PhGap;
    logged  = 1'b0;
  endtask

  task automatic model_exec();
    int op = m_ir / 4096;
    int a  = m_ir % 4096;
    m_phase = PhFetch;
    case (op)
      6:  m_pc = a;
      7:  if (m_z) m_pc = a;
      10: if (m_c) m_pc = a;
      11: if (m_n) m_pc = a;
      12: begin m_c = (m_acc >= 32768); m_acc = (m_acc * 2) % 65536; set_zn(); end
      13: begin m_c = (m_acc % 2 == 1); m_acc = m_acc / 2; set_zn(); end
      14: ;
      15: m_phase = PhHalt;
      default: m_phase = PhData;
    endcase
  endtask

  task automatic model_data();
    int op = m_ir / 4096;
    int mv = int'(dmem[m_ir % 4096]);
    case (op)
      0: begin m_c = (m_acc + mv > 65535); m_acc = (m_acc + mv) % 65536; end
      1: begin m_c = (mv > m_acc); m_acc = (m_acc - mv + 65536) % 65536; end
      2: begin m_acc = m_acc & mv; m_c = 1'b0; end
      3: begin m_acc = 65535 - mv; m_c = 1'b0; end
      4: begin m_acc = mv; m_c = 1'b0; end
      8: begin m_acc = m_acc | mv; m_c = 1'b0; end
      9: begin m_acc = m_acc ^ mv; m_c = 1'b0; end
      default: ;
    endcase
    if (op != 5) set_zn();
    m_phase = PhFetch;
  endtask

  // Memory responder plus per-cycle comparison against the model.
  initial begin : bus_and_check
    bus.iack = 1'b0; bus.dack = 1'b0; bus.idata = '0; bus.datai = '0;
    forever begin
      @(negedge clock);
      if (!active || !reset_n) begin
        bus.iack = 1'b0;
        bus.dack = 1'b0;
        continue;
      end
      cyc++;
      // Apply what the previous rising edge accepted.
      if (d_fire && d_we_s) begin
        dmem[d_addr_s] = d_data_s;
        wcount++;
      end
      if (m_phase == PhFetch && i_fire) model_fetch();
      else if (m_phase == PhGap) model_exec();
      else if (m_phase == PhData && d_fire) model_data();

      if (m_phase == PhFetch && !logged) begin
        fa.push_back(m_pc); fc.push_back(cyc); facc.push_back(m_acc);
        logged = 1'b1;
      end
      if (m_phase == PhHalt && halt_cyc < 0) halt_cyc = cyc;
      if (bus.dreq && bus.dwe) wcyc++;

      case (m_phase)
        PhFetch: begin
          check("fetch_ireq", 32'(bus.ireq), 32'd1);
          check("fetch_iaddr", 32'(bus.iaddr), 32'(m_pc));
          check("fetch_dreq", 32'(bus.dreq), 32'd0);
        end
        PhGap: begin
          check("exec_ireq", 32'(bus.ireq), 32'd0);
          check("exec_dreq", 32'(bus.dreq), 32'd0);
        end
        PhData: begin
          check("mem_dreq", 32'(bus.dreq), 32'd1);
          check("mem_ireq", 32'(bus.ireq), 32'd0);
          check("mem_daddr", 32'(bus.daddr), 32'(m_ir % 4096));
          check("mem_dwe", 32'(bus.dwe), 32'(m_ir / 4096 == 5));
          if (m_ir / 4096 == 5) check("mem_datao", 32'(bus.datao), 32'(m_acc));
        end
        default: begin
          check("halt_ireq", 32'(bus.ireq), 32'd0);
          check("halt_dreq", 32'(bus.dreq), 32'd0);
        end
      endcase
      check("halted", 32'(halted), 32'(m_phase == PhHalt));
      check("acc", 32'(acc_o), 32'(m_acc));

      // Drive acks for the coming rising edge.
      i_fire = 1'b0;
      d_fire = 1'b0;
      if (bus.ireq) begin
        ihold++;
        bus.idata = imem[bus.iaddr];
        bus.iack  = (ihold > iwait);
        if (bus.iack) begin i_fire = 1'b1; ihold = 0; end
      end else begin
        ihold = 0;
        bus.idata = 16'h5A5A;
        bus.iack  = noise;
      end
      if (bus.dreq) begin
        dhold++;
        bus.datai = dmem[bus.daddr];
        bus.dack  = (dhold > dwait);
        if (bus.dack) begin
          d_fire = 1'b1; dhold = 0;
          d_we_s = bus.dwe; d_addr_s = int'(bus.daddr); d_data_s = bus.datao;
        end
      end else begin
        dhold = 0;
        bus.datai = 16'hBEEF;
        bus.dack  = noise;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) begin
      imem[i] = 16'hF000;
      dmem[i] = 16'h0000;
    end
  endtask

  task automatic start_prog();
    @(negedge clock);
    #2;
    active  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_ireq", 32'(bus.ireq), 32'd0);
    check("rst_dreq", 32'(bus.dreq), 32'd0);
    check("rst_iaddr", 32'(bus.iaddr), 32'd0);
    check("rst_acc", 32'(acc_o), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    @(posedge clock);
    @(posedge clock);
    model_init();
    #1;
    reset_n = 1'b1;
    active  = 1'b1;
    #1;
    check("rel_ireq", 32'(bus.ireq), 32'd1);
    check("rel_iaddr", 32'(bus.iaddr), 32'd0);
  endtask

  task automatic wait_halt(input int bound);
    int n = 0;
    while (!(halt_cyc >= 0 && cyc >= halt_cyc + 6) && n < bound) begin
      @(negedge clock);
      n++;
    end
    check("halt_reached", 32'(n < bound), 32'd1);
    #2;
  endtask

  initial begin : stim
    int n;
    reset_n = 1'b0; active = 1'b0;
    iwait = 0; dwait = 0; noise = 1'b0;

    // Zero-wait LDA/ADD: acc wraps to 0 with Z=1, C=1 (both jumps taken).
    clear_mem();
    imem[0] = 16'h4010; imem[1] = 16'h0011; imem[2] = 16'h7004;
    imem[4] = 16'hA006;
    dmem[16'h010] = 16'hFFFF; dmem[16'h011] = 16'h0001;
    start_prog();
    wait_halt(200);
    check("p1_fetch2_cyc", 32'(fc[2]), 32'd6);
    check("p1_fa3", 32'(fa[3]), 32'h004);
    check("p1_fa4", 32'(fa[4]), 32'h006);
    check("p1_halt_cyc", 32'(halt_cyc), 32'd12);
    check("p1_acc", 32'(acc_o), 32'h0000);
    check("p1_halted", 32'(halted), 32'd1);

    // STA with three data wait states and spurious acks while idle.
    clear_mem();
    imem[0] = 16'h4030; imem[1] = 16'h5020;
    dmem[16'h030] = 16'h1234;
    dwait = 3; noise = 1'b1;
    start_prog();
    wait_halt(300);
    check("p2_write_cycles", 32'(wcyc), 32'd4);
    check("p2_write_count", 32'(wcount), 32'd1);
    check("p2_mem20", 32'(dmem[16'h020]), 32'h1234);
    check("p2_halt_cyc", 32'(halt_cyc), 32'd14);

    // Branches, one wait state on each port.
    clear_mem();
    imem[0] = 16'h4040; imem[1] = 16'h1041; imem[2] = 16'h7050;
    imem[3] = 16'h4042; imem[4] = 16'h7050;
    imem[16'h050] = 16'h4043; imem[16'h051] = 16'hB060;
    imem[16'h060] = 16'h4041; imem[16'h061] = 16'h1040; imem[16'h062] = 16'hA070;
    dmem[16'h040] = 16'h0005; dmem[16'h041] = 16'h0003;
    dmem[16'h042] = 16'h0000; dmem[16'h043] = 16'h8000;
    iwait = 1; dwait = 1; noise = 1'b1;
    start_prog();
    wait_halt(400);
    check("p3_jz_not_taken", 32'(fa[3]), 32'h003);
    check("p3_jz_taken", 32'(fa[5]), 32'h050);
    check("p3_jn_taken", 32'(fa[7]), 32'h060);
    check("p3_jc_taken", 32'(fa[10]), 32'h070);
    check("p3_halt_cyc", 32'(halt_cyc), 32'd45);
    check("p3_acc", 32'(acc_o), 32'hFFFE);

    // PC wrap, shifts and the logic ops.
    clear_mem();
    imem[0] = 16'hA003; imem[1] = 16'h4010; imem[2] = 16'h6FFF;
    imem[16'hFFF] = 16'hC000;
    imem[3] = 16'hD000; imem[4] = 16'hD000; imem[5] = 16'hA007;
    imem[7] = 16'h9011; imem[8] = 16'h8012; imem[9] = 16'h2013;
    imem[10] = 16'h3014; imem[11] = 16'hE000; imem[12] = 16'hB00E;
    dmem[16'h010] = 16'h8001; dmem[16'h011] = 16'h00F0; dmem[16'h012] = 16'h0F00;
    dmem[16'h013] = 16'h00FF; dmem[16'h014] = 16'h00F0;
    iwait = 0; dwait = 0; noise = 1'b0;
    start_prog();
    wait_halt(300);
    check("p4_fa3", 32'(fa[3]), 32'hFFF);
    check("p4_wrap", 32'(fa[4]), 32'h000);
    check("p4_shl_acc", 32'(facc[4]), 32'h0002);
    check("p4_jc_after_shl", 32'(fa[5]), 32'h003);
    check("p4_jn_taken", 32'(fa[14]), 32'h00E);
    check("p4_halt_cyc", 32'(halt_cyc), 32'd35);
    check("p4_acc", 32'(acc_o), 32'hFF0F);

    // HLT is sticky under ack pulses.
    clear_mem();
    noise = 1'b1;
    start_prog();
    wait_halt(100);
    repeat (10) @(negedge clock);
    #2;
    check("p5_halt_cyc", 32'(halt_cyc), 32'd2);
    check("p5_halted", 32'(halted), 32'd1);
    check("p5_no_ireq", 32'(bus.ireq), 32'd0);

    // Reset mid-MEM aborts the read; then a clean restart at 0.
    clear_mem();
    imem[0] = 16'h4010;
    dmem[16'h010] = 16'h5A5A;
    noise = 1'b0; dwait = 20;
    start_prog();
    n = 0;
    while (!bus.dreq && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("p6_dreq_seen", 32'(bus.dreq), 32'd1);
    repeat (3) @(negedge clock);
    #1;
    active  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("p6_abort_dreq", 32'(bus.dreq), 32'd0);
    check("p6_abort_daddr", 32'(bus.daddr), 32'd0);
    check("p6_abort_ireq", 32'(bus.ireq), 32'd0);
    dwait = 0;
    start_prog();
    wait_halt(100);
    check("p6_acc", 32'(acc_o), 32'h5A5A);
    check("p6_no_write", 32'(wcount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
